// File: rtl/branch_pkg.sv
// Shared RV32I control-flow encodings and branch-history types for the
// branch resolution unit and its history table.
package branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_INIT = 2'b01;

  typedef enum logic [1:0] {
    CF_NONE,
    CF_BRANCH,
    CF_JAL,
    CF_JALR
  } cf_kind_t;

  function automatic cf_kind_t cf_classify(input logic [6:0] opcode);
    cf_kind_t kind;
    kind = CF_NONE;
    case (opcode)
      OP_BRANCH: kind = CF_BRANCH;
      OP_JAL:    kind = CF_JAL;
      OP_JALR:   kind = CF_JALR;
      default:   kind = CF_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2-bit saturating counters, combinational lookup and a
// single clocked update port. Lookup has no write bypass.
module branch_bht
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lk_pc,
  output logic            lk_taken,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken
);

  localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

  bht_ctr_t         r_ctr [BHT_ENTRIES];
  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic             w_unused_pc_bits;

  function automatic bht_ctr_t sat_update(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

  // Word-aligned PCs: bits [1:0] never select an entry.
  assign w_lk_idx  = lk_pc[IDX_W+1:2];
  assign w_upd_idx = upd_pc[IDX_W+1:2];

  assign w_unused_pc_bits = ^{lk_pc[XLEN-1:IDX_W+2], lk_pc[1:0],
                              upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0]};

  assign lk_taken = r_ctr[w_lk_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_ctr[i] <= BHT_INIT;
      end
    end else if (upd_en) begin
      r_ctr[w_upd_idx] <= sat_update(r_ctr[w_upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Registered branch resolution for RV32I: direction, redirect target, link
// address, misprediction flag, BHT training and performance counters.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rdata1,
  input  logic [XLEN-1:0]  rdata2,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_link,
  output logic             out_mispredict,
  input  logic [XLEN-1:0]  lk_pc,
  output logic             lk_taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  cf_kind_t                 w_kind;
  logic signed [XLEN-1:0]   w_rs1_s;
  logic signed [XLEN-1:0]   w_rs2_s;
  logic                     w_eq;
  logic                     w_lt;
  logic                     w_ltu;
  logic                     w_cond_ok;
  logic                     w_br_taken;
  logic                     w_taken;
  logic [XLEN-1:0]          w_pc_plus4;
  logic [XLEN-1:0]          w_pc_imm;
  logic [XLEN-1:0]          w_jalr_sum;
  logic [XLEN-1:0]          w_target;
  logic                     w_mispredict;
  logic                     w_accept;
  logic                     w_is_cf;
  logic                     w_bht_upd;

  logic                     r_vld_p1;
  logic                     r_taken_p1;
  logic [XLEN-1:0]          r_target_p1;
  logic [XLEN-1:0]          r_link_p1;
  logic                     r_mispredict_p1;
  logic [CNT_W-1:0]         r_br_count;
  logic [CNT_W-1:0]         r_mp_count;

  // Stage p0: combinational resolve of the presented instruction
  assign w_kind  = cf_classify(opcode);
  assign w_rs1_s = rdata1;
  assign w_rs2_s = rdata2;
  assign w_eq    = (rdata1 == rdata2);
  assign w_lt    = (w_rs1_s < w_rs2_s);
  assign w_ltu   = (rdata1 < rdata2);

  always_comb begin
    w_cond_ok  = 1'b1;
    w_br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  w_br_taken = w_eq;
      F3_BNE:  w_br_taken = !w_eq;
      F3_BLT:  w_br_taken = w_lt;
      F3_BGE:  w_br_taken = !w_lt;
      F3_BLTU: w_br_taken = w_ltu;
      F3_BGEU: w_br_taken = !w_ltu;
      default: w_cond_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (w_kind)
      CF_BRANCH: w_taken = w_br_taken;
      CF_JAL,
      CF_JALR:   w_taken = 1'b1;
      default:   w_taken = 1'b0;
    endcase
  end

  assign w_pc_plus4 = pc + XLEN'(4);
  assign w_pc_imm   = pc + imm;
  assign w_jalr_sum = rdata1 + imm;

  always_comb begin
    w_target = w_pc_plus4;
    if (w_taken) begin
      w_target = (w_kind == CF_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_pc_imm;
    end
  end

  always_comb begin
    w_mispredict = 1'b0;
    case (w_kind)
      CF_BRANCH,
      CF_JAL:  w_mispredict = (w_taken != pred_taken) ||
                              (w_taken && pred_taken && (pred_target != w_target));
      CF_JALR: w_mispredict = !pred_taken || (pred_target != w_target);
      default: w_mispredict = pred_taken;
    endcase
  end

  assign in_ready  = !flush && (!r_vld_p1 || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_is_cf   = (w_kind != CF_NONE);
  // Reserved funct3 codes under the branch opcode leave the history untouched.
  assign w_bht_upd = w_accept && (w_kind == CF_BRANCH) && w_cond_ok;

  branch_bht #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .XLEN        (XLEN)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .lk_pc     (lk_pc),
    .lk_taken  (lk_taken),
    .upd_en    (w_bht_upd),
    .upd_pc    (pc),
    .upd_taken (w_taken)
  );

  // Stage p1: single-entry output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1        <= 1'b0;
      r_taken_p1      <= 1'b0;
      r_target_p1     <= '0;
      r_link_p1       <= '0;
      r_mispredict_p1 <= 1'b0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1        <= 1'b1;
      r_taken_p1      <= w_taken;
      r_target_p1     <= w_target;
      r_link_p1       <= w_pc_plus4;
      r_mispredict_p1 <= w_mispredict;
    end else if (out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_count <= '0;
      r_mp_count <= '0;
    end else if (w_accept && w_is_cf) begin
      r_br_count <= r_br_count + CNT_W'(1);
      if (w_mispredict) r_mp_count <= r_mp_count + CNT_W'(1);
    end
  end

  assign out_valid      = r_vld_p1;
  assign out_taken      = r_taken_p1;
  assign out_target     = r_target_p1;
  assign out_link       = r_link_p1;
  assign out_mispredict = r_mispredict_p1;
  assign br_count       = r_br_count;
  assign mp_count       = r_mp_count;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: compares, targets, BHT training,
// backpressure, flush and asynchronous reset.
module tb_branch_resolve;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [31:0] out_target;
  logic [31:0] out_link;
  logic        out_mispredict;
  logic [31:0] lk_pc;
  logic        lk_taken;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  int n_checks;
  int n_errors;

  branch_resolve #(
    .XLEN        (32),
    .BHT_ENTRIES (64),
    .CNT_W       (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .opcode         (opcode),
    .funct3         (funct3),
    .pc             (pc),
    .imm            (imm),
    .rdata1         (rdata1),
    .rdata2         (rdata2),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_taken      (out_taken),
    .out_target     (out_target),
    .out_link       (out_link),
    .out_mispredict (out_mispredict),
    .lk_pc          (lk_pc),
    .lk_taken       (lk_taken),
    .br_count       (br_count),
    .mp_count       (mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] p, input logic [31:0] im,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic pt, input logic [31:0] ptg);
    opcode      = opc;
    funct3      = f3;
    pc          = p;
    imm         = im;
    rdata1      = r1;
    rdata2      = r2;
    pred_taken  = pt;
    pred_target = ptg;
  endtask

  task automatic check_out(input string tag, input logic tk, input logic [31:0] tgt,
                           input logic [31:0] lnk, input logic mp);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_taken"}, 64'(out_taken), 64'(tk));
    check({tag, "_target"}, 64'(out_target), 64'(tgt));
    check({tag, "_link"}, 64'(out_link), 64'(lnk));
    check({tag, "_misp"}, 64'(out_mispredict), 64'(mp));
  endtask

  task automatic check_cnt(input string tag, input int br, input int mp);
    check({tag, "_br"}, 64'(br_count), 64'(br));
    check({tag, "_mp"}, 64'(mp_count), 64'(mp));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    lk_pc     = 32'h40;
    set_op(7'b0110011, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_taken", 64'(out_taken), 64'd0);
    check("rst_target", 64'(out_target), 64'd0);
    check("rst_link", 64'(out_link), 64'd0);
    check("rst_misp", 64'(out_mispredict), 64'd0);
    check_cnt("rst", 0, 0);
    check("rst_lk", 64'(lk_taken), 64'd0);
    step();
    step();
    rst = 1'b0;

    // Signed vs unsigned compare on the same operands
    set_op(7'b1100011, 3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0);
    in_valid = 1'b1;
    step();
    check_out("blt", 1'b1, 32'h120, 32'h104, 1'b1);
    check_cnt("blt", 1, 1);

    set_op(7'b1100011, 3'b110, 32'h200, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0);
    step();
    check_out("bltu", 1'b0, 32'h204, 32'h204, 1'b0);
    check_cnt("bltu", 2, 1);

    // JALR clears bit 0 of the sum
    set_op(7'b1100111, 3'b000, 32'h300, 32'h4, 32'h1001, 32'h0, 1'b1, 32'h1004);
    step();
    check_out("jalr", 1'b1, 32'h1004, 32'h304, 1'b0);
    check_cnt("jalr", 3, 1);

    // JAL with a negative offset, predicted not-taken
    set_op(7'b1101111, 3'b000, 32'h400, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    check_out("jal", 1'b1, 32'h3F0, 32'h404, 1'b1);
    check_cnt("jal", 4, 2);

    // Non-control instruction predicted taken: flagged but not counted
    set_op(7'b0110011, 3'b000, 32'h500, 32'h8, 32'h0, 32'h0, 1'b1, 32'h508);
    step();
    check_out("alu", 1'b0, 32'h504, 32'h504, 1'b1);
    check_cnt("alu", 4, 2);

    // Reserved funct3 under branch opcode at pc 0x80 (must not train BHT)
    set_op(7'b1100011, 3'b010, 32'h80, 32'h8, 32'h5, 32'h5, 1'b0, 32'h0);
    step();
    check_out("rsvd", 1'b0, 32'h84, 32'h84, 1'b0);
    check_cnt("rsvd", 5, 2);

    in_valid = 1'b0;
    step();
    check("drain_valid", 64'(out_valid), 64'd0);

    // BHT training at pc 0x40, aliasing with 0x140
    lk_pc = 32'h40;
    set_op(7'b1100011, 3'b000, 32'h40, 32'h8, 32'h5, 32'h5, 1'b0, 32'h0);
    in_valid = 1'b1;
    #1;
    check("bht_init", 64'(lk_taken), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bht_tk%0d", i), 64'(lk_taken), 64'd1);
    end
    check_cnt("bht_tk", 8, 5);
    lk_pc = 32'h140;
    #1;
    check("bht_alias_tk", 64'(lk_taken), 64'd1);
    lk_pc = 32'h40;
    rdata2 = 32'h6;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("bht_nt%0d", i), 64'(lk_taken), (i == 0) ? 64'd1 : 64'd0);
    end
    check_cnt("bht_nt", 12, 5);
    lk_pc = 32'h140;
    #1;
    check("bht_alias_nt", 64'(lk_taken), 64'd0);
    in_valid = 1'b0;
    step();

    // Backpressure: A held in output register while B waits
    out_ready = 1'b0;
    set_op(7'b1100011, 3'b000, 32'h500, 32'h10, 32'h7, 32'h7, 1'b0, 32'h0);
    in_valid = 1'b1;
    step();
    check_out("bp_a", 1'b1, 32'h510, 32'h504, 1'b1);
    check_cnt("bp_a", 13, 6);
    set_op(7'b1100011, 3'b001, 32'h600, 32'h20, 32'h1, 32'h1, 1'b0, 32'h0);
    #1;
    check("bp_ready0", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("bp_hold%0d", i), 1'b1, 32'h510, 32'h504, 1'b1);
      check($sformatf("bp_rdy%0d", i), 64'(in_ready), 64'd0);
    end
    check_cnt("bp_hold", 13, 6);
    out_ready = 1'b1;
    #1;
    check("bp_ready1", 64'(in_ready), 64'd1);
    step();
    check_out("bp_b", 1'b0, 32'h604, 32'h604, 1'b0);
    check_cnt("bp_b", 14, 6);
    in_valid = 1'b0;
    step();
    check("bp_drain", 64'(out_valid), 64'd0);

    // Flush while a result is held and a BNE at 0x80 is presented
    out_ready = 1'b0;
    set_op(7'b1101111, 3'b000, 32'h700, 32'h10, 32'h0, 32'h0, 1'b0, 32'h0);
    in_valid = 1'b1;
    step();
    check_out("fl_jal", 1'b1, 32'h710, 32'h704, 1'b1);
    check_cnt("fl_jal", 15, 7);
    set_op(7'b1100011, 3'b001, 32'h80, 32'h8, 32'h1, 32'h2, 1'b0, 32'h0);
    flush = 1'b1;
    #1;
    check("fl_ready", 64'(in_ready), 64'd0);
    step();
    check("fl_valid", 64'(out_valid), 64'd0);
    check_cnt("fl", 15, 7);
    lk_pc = 32'h80;
    #1;
    check("fl_bht", 64'(lk_taken), 64'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();

    // Asynchronous reset between edges
    out_ready = 1'b0;
    set_op(7'b1100011, 3'b000, 32'h80, 32'h8, 32'h3, 32'h3, 1'b0, 32'h0);
    in_valid = 1'b1;
    step();
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    check("ar_pre_lk", 64'(lk_taken), 64'd1);
    check_cnt("ar_pre", 16, 8);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_target", 64'(out_target), 64'd0);
    check("ar_link", 64'(out_link), 64'd0);
    check("ar_lk", 64'(lk_taken), 64'd0);
    check_cnt("ar", 0, 0);
    #1;
    rst = 1'b0;
    step();
    check("ar_post_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    check("ar_retrain_lk", 64'(lk_taken), 64'd1);
    check_out("ar_retrain", 1'b1, 32'h88, 32'h84, 1'b1);
    check_cnt("ar_retrain", 1, 1);
    in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
